tour_cmd_sequencer: RTL and testbench
=====================================

Name: tour_cmd_sequencer

Overview:
- Sits between the UART command path (UART_wrapper) and cmd_proc inside KnightsTour.
- Idle: transparent pass-through of UART commands and responses.
- After start_tour: takes ownership of cmd_proc. Walks the solved move list from the tour-solver memory, splitting each knight move into a vertical leg then a horizontal leg. The horizontal leg carries fanfare.
- Returns an intermediate response per leg and the final ack after the last move.

Parameters:
NUM_MOVES, 24, number of knight moves in a full tour (5x5 board).
IDX_W, 5, width of move index; must satisfy 2**IDX_W >= NUM_MOVES.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_tour  in  1  one-cycle pulse from cmd_proc, tour solution ready
mv_indx  out  IDX_W  address into tour move memory
move  in  8  one-hot knight move at mv_indx, combinational read
cmd_UART  in  16  command from UART_wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy_UART  out  1  consume pulse back to UART_wrapper
cmd  out  16  command to cmd_proc
cmd_rdy  out  1  command valid to cmd_proc
clr_cmd_rdy  in  1  cmd_proc has consumed cmd
send_resp  in  1  cmd_proc finished executing a command
resp  out  8  response byte to UART_wrapper
tour_err  out  1  sticky, illegal move word seen

Behaviour:
- Single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, mv_indx=0, tour_err=0, cmd_rdy=0, clr_cmd_rdy_UART=0, resp=8'hA5, cmd=cmd_UART.
- States:
  - IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5. On start_tour: mv_indx<=0, tour_err<=0, go to VERT.
  - VERT: cmd={4'b0010, hdg, 4'(|dy|)}; hdg=8'h00 if dy>0 (north), 8'h7F if dy<0 (south). cmd_rdy=1 until clr_cmd_rdy, then go to HOLDV.
  - HOLDV: cmd_rdy=0, resp=8'h5A. On send_resp go to HORZ.
  - HORZ: cmd={4'b0011, hdg, 4'(|dx|)}; hdg=8'hBF if dx>0 (east), 8'h3F if dx<0 (west). cmd_rdy=1 until clr_cmd_rdy, then go to HOLDH.
  - HOLDH: on send_resp:
    - if mv_indx==NUM_MOVES-1: resp=8'hA5 that cycle, mv_indx<=0, go to IDLE.
    - else: resp=8'h5A, mv_indx<=mv_indx+1, go to VERT.
- Move decode, (dx,dy) per bit:
  - b0 (+1,+2), b1 (-1,+2), b2 (-2,+1), b3 (-2,-1)
  - b4 (-1,-2), b5 (+1,-2), b6 (+2,-1), b7 (+2,+1)
- Illegal move: move not exactly one-hot when sampled in VERT. Set tour_err<=1, go to IDLE, cmd_rdy stays 0.
- mv_indx is stable from VERT entry through HOLDH.
- In non-IDLE states:
  - cmd_rdy_UART is ignored.
  - clr_cmd_rdy_UART=0, so a pending UART command waits until IDLE.
  - start_tour is ignored.
- clr_cmd_rdy and send_resp in the same cycle in VERT/HORZ: clr_cmd_rdy moves to the HOLD state; send_resp is acted on only in HOLD states.
- Latency: cmd_rdy rises 1 cycle after start_tour and 1 cycle after each send_resp.
- Reset mid-tour aborts immediately to IDLE with reset values.

Decomposition:
- Package kt_pkg holds:
  - opcode constants: OP_CAL=4'b0000, OP_MOVE=4'b0010, OP_MOVE_FAN=4'b0011, OP_TOUR=4'b0100
  - heading constants: H_NORTH, H_WEST, H_SOUTH, H_EAST
  - RESP_ACK=8'hA5, RESP_LEG=8'h5A
  - state enum
- One combinational sub-module, knight_move_decode: input move[7:0]; outputs signed dx, signed dy, legal.

Test Plan:
- Idle pass-through: cmd_UART=16'h2001, cmd_rdy_UART=1 -> cmd=16'h2001, cmd_rdy=1; clr_cmd_rdy pulse -> clr_cmd_rdy_UART pulse same cycle; resp=8'hA5.
- Single move b0 with NUM_MOVES=1: start_tour -> cmd=16'h2002, then after clr/send_resp cmd=16'h3BF1. Final send_resp -> resp=8'hA5, state IDLE.
- Move b3: vertical cmd=16'h27F1 (south 1), horizontal cmd=16'h33F2 (west 2); intermediate resp=8'h5A.
- Full 24-move list from memory model: mv_indx steps 0..23, 48 commands issued, exactly one 8'hA5 at end; cmd_rdy_UART held high during tour never gets clr_cmd_rdy_UART until IDLE.
- Illegal move 8'h03 at index 5 -> tour_err=1, back to IDLE, no command issued for index 5.
- rst_n low during HOLDH -> cmd_rdy=0, mv_indx=0, resp=8'hA5 asynchronously; second start_tour during tour ignored.

Source files
------------

// File: rtl/kt_pkg.sv
// -----------------------------------------------------------------------------
// kt_pkg
// Shared definitions for the KnightsTour command path: command opcodes,
// heading codes carried in cmd[11:4], response bytes returned to the UART,
// the tour sequencer state encoding and a magnitude helper for leg lengths.
// -----------------------------------------------------------------------------
package kt_pkg;

    // Command opcodes (cmd[15:12])
    localparam logic [3:0] OP_CAL      = 4'b0000;
    localparam logic [3:0] OP_MOVE     = 4'b0010;
    localparam logic [3:0] OP_MOVE_FAN = 4'b0011;
    localparam logic [3:0] OP_TOUR     = 4'b0100;

    // Heading codes (cmd[11:4])
    localparam logic [7:0] H_NORTH = 8'h00;
    localparam logic [7:0] H_WEST  = 8'h3F;
    localparam logic [7:0] H_SOUTH = 8'h7F;
    localparam logic [7:0] H_EAST  = 8'hBF;

    // Response bytes
    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_LEG = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VERT  = 3'd1,
        S_HOLDV = 3'd2,
        S_HORZ  = 3'd3,
        S_HOLDH = 3'd4
    } state_t;

    // Absolute value of a leg displacement (-2..+2), zero-extended to the
    // 4-bit square-count field of a move command.
    function automatic logic [3:0] mag4(input logic signed [2:0] v);
        logic signed [2:0] a;
        if (v < 3'sd0) begin
            a = -v;
        end else begin
            a = v;
        end
        return {1'b0, a};
    endfunction

endpackage

// File: rtl/knight_move_decode.sv
// -----------------------------------------------------------------------------
// knight_move_decode
// Purely combinational decode of a one-hot knight move into signed board
// displacements.
//   move_i  [7:0]  one-hot move word from the tour-solver memory
//   dx_o    [2:0]  signed column displacement (+ = east)
//   dy_o    [2:0]  signed row displacement (+ = north)
//   legal_o        move word has exactly one bit set
// Non one-hot words decode to (0,0) and drop legal_o.
// -----------------------------------------------------------------------------
module knight_move_decode (
    input  logic        [7:0] move_i,
    output logic signed [2:0] dx_o,
    output logic signed [2:0] dy_o,
    output logic              legal_o
);

    // One-hot move word to (dx,dy) lookup
    always_comb begin
        dx_o    = 3'sd0;
        dy_o    = 3'sd0;
        legal_o = $onehot(move_i);
        case (move_i)
            8'h01:   begin dx_o =  3'sd1; dy_o =  3'sd2; end
            8'h02:   begin dx_o = -3'sd1; dy_o =  3'sd2; end
            8'h04:   begin dx_o = -3'sd2; dy_o =  3'sd1; end
            8'h08:   begin dx_o = -3'sd2; dy_o = -3'sd1; end
            8'h10:   begin dx_o = -3'sd1; dy_o = -3'sd2; end
            8'h20:   begin dx_o =  3'sd1; dy_o = -3'sd2; end
            8'h40:   begin dx_o =  3'sd2; dy_o = -3'sd1; end
            8'h80:   begin dx_o =  3'sd2; dy_o =  3'sd1; end
            default: begin dx_o =  3'sd0; dy_o =  3'sd0; end
        endcase
    end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tour_cmd_sequencer
// Sits between UART_wrapper and cmd_proc. While idle it is transparent to
// UART commands and responses. After start_tour it owns cmd_proc and plays
// the solved tour: each knight move becomes a vertical leg followed by a
// horizontal leg with fanfare, with a leg response after every leg and the
// ack after the final move.
//   clk, rst_n                    clock, asynchronous active-low reset
//   start_tour                    one-cycle pulse, tour solution ready
//   mv_indx  [IDX_W-1:0]          address into tour move memory
//   move     [7:0]                one-hot move at mv_indx (combinational)
//   cmd_UART, cmd_rdy_UART        command from UART_wrapper
//   clr_cmd_rdy_UART              consume pulse back to UART_wrapper
//   cmd, cmd_rdy                  command to cmd_proc
//   clr_cmd_rdy, send_resp        cmd_proc consume / completion strobes
//   resp     [7:0]                response byte to UART_wrapper
//   tour_err                      sticky, illegal move word seen
// -----------------------------------------------------------------------------
module tour_cmd_sequencer
    import kt_pkg::*;
#(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [7:0]       move,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_err
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   mv_indx_q, mv_indx_d;
    logic               tour_err_q, tour_err_d;

    logic signed [2:0]  dx_s, dy_s;
    logic               legal_s;
    logic               last_s;
    logic [15:0]        vert_cmd_s, horz_cmd_s;

    knight_move_decode u_decode (
        .move_i  (move),
        .dx_o    (dx_s),
        .dy_o    (dy_s),
        .legal_o (legal_s)
    );

    assign last_s     = (mv_indx_q == IDX_W'(NUM_MOVES - 1));
    assign vert_cmd_s = {OP_MOVE,     (dy_s < 3'sd0) ? H_SOUTH : H_NORTH, mag4(dy_s)};
    assign horz_cmd_s = {OP_MOVE_FAN, (dx_s < 3'sd0) ? H_WEST  : H_EAST,  mag4(dx_s)};

    assign mv_indx  = mv_indx_q;
    assign tour_err = tour_err_q;

    // Next-state and move-index sequencing; send_resp only matters in HOLD states
    always_comb begin
        state_d    = state_q;
        mv_indx_d  = mv_indx_q;
        tour_err_d = tour_err_q;
        case (state_q)
            S_IDLE: begin
                if (start_tour) begin
                    state_d    = S_VERT;
                    mv_indx_d  = '0;
                    tour_err_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_VERT: begin
                if (!legal_s) begin
                    // Corrupt move word: abandon the tour without issuing it
                    state_d    = S_IDLE;
                    mv_indx_d  = '0;
                    tour_err_d = 1'b1;
                end else if (clr_cmd_rdy) begin
                    state_d = S_HOLDV;
                end else begin
                    state_d = S_VERT;
                end
            end
            S_HOLDV: begin
                if (send_resp) begin
                    state_d = S_HORZ;
                end else begin
                    state_d = S_HOLDV;
                end
            end
            S_HORZ: begin
                if (clr_cmd_rdy) begin
                    state_d = S_HOLDH;
                end else begin
                    state_d = S_HORZ;
                end
            end
            S_HOLDH: begin
                if (send_resp && last_s) begin
                    state_d   = S_IDLE;
                    mv_indx_d = '0;
                end else if (send_resp) begin
                    state_d   = S_VERT;
                    mv_indx_d = mv_indx_q + IDX_W'(1);
                end else begin
                    state_d = S_HOLDH;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mv_indx_d = '0;
            end
        endcase
    end

    // State, index and error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mv_indx_q  <= '0;
            tour_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mv_indx_q  <= mv_indx_d;
            tour_err_q <= tour_err_d;
        end
    end

    // Output steering: UART pass-through when idle, tour legs otherwise.
    // cmd_rdy in VERT is gated by legality so a bad word is never offered.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_LEG;
        case (state_q)
            S_IDLE: begin
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_ACK;
            end
            S_VERT: begin
                cmd     = vert_cmd_s;
                cmd_rdy = legal_s;
            end
            S_HOLDV: begin
                cmd = vert_cmd_s;
            end
            S_HORZ: begin
                cmd     = horz_cmd_s;
                cmd_rdy = 1'b1;
            end
            S_HOLDH: begin
                cmd = horz_cmd_s;
                if (send_resp && last_s) begin
                    resp = RESP_ACK;
                end else begin
                    resp = RESP_LEG;
                end
            end
            default: begin
                cmd  = cmd_UART;
                resp = RESP_ACK;
            end
        endcase
    end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
module tb_tour_cmd_sequencer;

    localparam int NM = 24;

    typedef struct {
        logic [15:0] cmd;
        logic        pass;
        logic [4:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [4:0]  mv_indx;
    logic [7:0]  move;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;
    logic        tour_err;

    logic [7:0]  mem [32];
    exp_t        exp_q [$];
    logic [7:0]  resp_q [$];

    int errors = 0;
    int checks = 0;
    int sends_done = 0;
    int send_limit = 1 << 30;
    bit abort_send = 1'b0;

    // Knight displacement per move bit
    int DX [8] = '{ 1, -1, -2, -2, -1,  1,  2,  2};
    int DY [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

    assign move = mem[mv_indx];

    tour_cmd_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .mv_indx          (mv_indx),
        .move             (move),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp),
        .tour_err         (tour_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Model of one knight move: two leg commands and their responses
    task automatic push_move(input int i);
        int pos, dx, dy, v;
        pos = -1;
        for (int b = 0; b < 8; b++) begin
            if (mem[i] == (8'h01 << b)) pos = b;
        end
        dx = DX[pos];
        dy = DY[pos];
        v = 'h2000 + ((dy > 0) ? 'h00 : 'h7F) * 16 + ((dy < 0) ? -dy : dy);
        exp_q.push_back('{cmd: 16'(v), pass: 1'b0, idx: 5'(i)});
        resp_q.push_back(8'h5A);
        v = 'h3000 + ((dx > 0) ? 'hBF : 'h3F) * 16 + ((dx < 0) ? -dx : dx);
        exp_q.push_back('{cmd: 16'(v), pass: 1'b0, idx: 5'(i)});
        resp_q.push_back((i == NM - 1) ? 8'hA5 : 8'h5A);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'h01 << $urandom_range(0, 7);
    endtask

    // Wait for scoreboard to drain; optionally release UART cmd and re-pulse start
    task automatic drain(input string nm, input bit hold_uart, input int restart_at);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            #2;
            if (c == restart_at) start_tour = 1'b1;
            else start_tour = 1'b0;
            if (hold_uart && clr_cmd_rdy_UART) cmd_rdy_UART = 1'b0;
            if (exp_q.size() == 0 && resp_q.size() == 0 && !send_resp && !clr_cmd_rdy)
                done = 1'b1;
        end
        start_tour = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cmds %0d resps pending, required 0", nm, exp_q.size(), resp_q.size());
            exp_q.delete();
            resp_q.delete();
        end
    endtask

    task automatic pulse_start(input bit hold_uart, input logic [15:0] ucmd);
        @(negedge clk);
        #2;
        start_tour = 1'b1;
        if (hold_uart) begin
            cmd_UART = ucmd;
            cmd_rdy_UART = 1'b1;
        end
        @(posedge clk);
        #1 start_tour = 1'b0;
        @(negedge clk);
        #1 chk("start_latency", 32'(cmd_rdy), 32'($onehot(mem[0])));
    endtask

    task automatic run_tour(input string nm, input int bad_idx, input bit hold_uart, input int restart_at);
        int n_ok;
        logic [15:0] ucmd;
        logic [7:0] bad;
        ucmd = 16'($urandom);
        if (bad_idx >= 0) begin
            if (bad_idx == 5) bad = 8'h03;
            else begin
                bad = 8'($urandom);
                while ($countones(bad) == 1) bad = 8'($urandom);
            end
            mem[bad_idx] = bad;
            n_ok = bad_idx;
        end else n_ok = NM;
        for (int i = 0; i < n_ok; i++) push_move(i);
        if (hold_uart) begin
            exp_q.push_back('{cmd: ucmd, pass: 1'b1, idx: 5'd0});
            resp_q.push_back(8'hA5);
        end
        pulse_start(hold_uart, ucmd);
        drain(nm, hold_uart, restart_at);
        repeat (3) @(negedge clk);
        #1;
        chk({nm, "_tour_err"}, 32'(tour_err), 32'(bad_idx >= 0));
        chk({nm, "_idle_rdy"}, 32'(cmd_rdy), 32'd0);
        chk({nm, "_idle_resp"}, 32'(resp), 32'hA5);
    endtask

    task automatic uart_cmd(input logic [15:0] v);
        exp_q.push_back('{cmd: v, pass: 1'b1, idx: 5'd0});
        resp_q.push_back(8'hA5);
        @(negedge clk);
        #2;
        cmd_UART = v;
        cmd_rdy_UART = 1'b1;
        drain("uart", 1'b1, -1);
    endtask

    // cmd_proc model + monitor: consumes offered commands and checks against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_rdy) begin
                e = '{cmd: 16'h0000, pass: 1'b0, idx: 5'd0};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got cmd %0h, required none", cmd);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd", 32'(cmd), 32'(e.cmd));
                    chk("mv_indx", 32'(mv_indx), 32'(e.idx));
                end
                clr_cmd_rdy = 1'b1;
                #1 chk("clr_uart", 32'(clr_cmd_rdy_UART), 32'(e.pass));
                @(posedge clk);
                #1 clr_cmd_rdy = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                while (sends_done >= send_limit && !abort_send) @(negedge clk);
                if (!abort_send) begin
                    @(negedge clk);
                    sends_done++;
                    send_resp = 1'b1;
                    #1;
                    if (resp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got resp %0h, required none", resp);
                    end else begin
                        chk("resp", 32'(resp), 32'(resp_q.pop_front()));
                    end
                    @(posedge clk);
                    #1 send_resp = 1'b0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h01;
        cmd_UART = 16'h1234;
        #12;
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_mv_indx", 32'(mv_indx), 32'd0);
        chk("rst_tour_err", 32'(tour_err), 32'd0);
        chk("rst_resp", 32'(resp), 32'hA5);
        chk("rst_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'h1234);
        @(negedge clk);
        #2 rst_n = 1'b1;

        uart_cmd(16'h2001);

        // Directed first moves b0 and b3, UART command held across the tour, second start ignored
        fill_mem();
        mem[0] = 8'h01;
        mem[1] = 8'h08;
        run_tour("tour_full", -1, 1'b1, 40);

        fill_mem();
        run_tour("tour_illegal5", 5, 1'b0, -1);

        for (int t = 0; t < 3; t++) begin
            fill_mem();
            if (t == 1) run_tour("tour_rand_bad", int'($urandom_range(0, NM - 1)), 1'b0, -1);
            else run_tour("tour_rand", -1, (t == 2), int'($urandom_range(10, 200)));
        end

        // Reset while parked in HOLDH of move 1
        fill_mem();
        push_move(0);
        push_move(1);
        void'(resp_q.pop_back());
        send_limit = sends_done + 3;
        pulse_start(1'b0, 16'h0000);
        drain("pre_reset", 1'b0, -1);
        repeat (3) @(negedge clk);
        #1;
        chk("holdh_mv_indx", 32'(mv_indx), 32'd1);
        chk("holdh_resp", 32'(resp), 32'h5A);
        chk("holdh_cmd_rdy", 32'(cmd_rdy), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("arst_mv_indx", 32'(mv_indx), 32'd0);
        chk("arst_resp", 32'(resp), 32'hA5);
        abort_send = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        abort_send = 1'b0;
        send_limit = 1 << 30;

        fill_mem();
        run_tour("tour_after_rst", -1, 1'b0, -1);
        uart_cmd(16'($urandom));

        repeat (5) @(negedge clk);
        chk("leftover_cmds", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
